// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the staggered reset sequencer.
// The optional sequence counter is enabled with RESET_SEQ_COUNT_EN.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } seq_state_e;

   localparam int                     SEQ_COUNT_W   = 8;
   localparam logic [SEQ_COUNT_W-1:0] SEQ_COUNT_MAX = 8'hFF;

   // The timer is loaded with at most max(hold-1, stagger), so this width never wraps.
   function automatic int tmr_width(input int hold, input int stagger);
      int m;
      m = (hold > stagger) ? hold : stagger;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

   function automatic bit params_ok(input int num_out, input int hold, input int stagger);
      return (num_out >= 1) && (num_out <= 16) && (hold >= 1) && (stagger >= 1);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the sequencer FSM (master) and its down-counter (slave).
interface reset_sequencer_if #(parameter int W = 4);
   logic         clr;
   logic         load;
   logic [W-1:0] load_val;
   logic         expire;
   logic         idle;

   modport master (output clr, load, load_val, input expire, idle);
   modport slave  (input clr, load, load_val, output expire, idle);
endinterface

// File: rtl/reset_seq_timer.sv
// Loadable down-counter; expire flags the last counted cycle, idle flags a cleared counter.
module reset_seq_timer #(
   parameter int W = 4
) (
   input  logic              clk,
   input  logic              rst,
   reset_sequencer_if.slave  tif
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || tif.clr)
         cnt <= '0;
      else if (tif.load)
         cnt <= tif.load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   // Loading L in cycle D makes expire true in cycle D+L.
   assign tif.expire = (cnt == W'(1));
   assign tif.idle   = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staggered reset release: hold all domains, release one every STAGGER_CYCLES, then run.
// Optional seq_count output of software-triggered sequences when RESET_SEQ_COUNT_EN is defined.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_OUT        = 6,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4
) (
   input  logic               auto_in_clock,
   input  logic               auto_in_reset,
   input  logic               sw_reset_req,
   output logic [NUM_OUT-1:0] auto_out_clock,
   output logic [NUM_OUT-1:0] auto_out_reset,
   output logic               seq_done
`ifdef RESET_SEQ_COUNT_EN
   ,
   output logic [SEQ_COUNT_W-1:0] seq_count
`endif
);
   localparam int TW = tmr_width(HOLD_CYCLES, STAGGER_CYCLES);
   localparam int IW = $clog2(NUM_OUT + 1);
   localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] STAG_LD  = TW'(STAGGER_CYCLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OUT - 1);
   localparam logic [IW-1:0] DONE_IDX = IW'(NUM_OUT);

   generate
      if (!params_ok(NUM_OUT, HOLD_CYCLES, STAGGER_CYCLES)) begin : g_bad_params
         $error("reset_sequencer: illegal NUM_OUT/HOLD_CYCLES/STAGGER_CYCLES");
      end
   endgenerate

   assign auto_out_clock = {NUM_OUT{auto_in_clock}};

   seq_state_e    state;
   logic [IW-1:0] idx;
   logic          release_now;

   reset_sequencer_if #(.W(TW)) tif ();

   reset_seq_timer #(.W(TW)) u_timer (
      .clk (auto_in_clock),
      .rst (auto_in_reset),
      .tif (tif.slave)
   );

   always_comb begin
      release_now  = 1'b0;
      tif.clr      = sw_reset_req;
      tif.load     = 1'b0;
      tif.load_val = STAG_LD;
      case (state)
         ST_ASSERT:  release_now = (HOLD_CYCLES == 1) || tif.expire;
         ST_RELEASE: release_now = (idx != DONE_IDX) && tif.expire;
         default:    release_now = 1'b0;
      endcase
      // A freshly cleared timer in ASSERT is cycle 0: arm the hold window.
      if (state == ST_ASSERT && tif.idle && HOLD_CYCLES > 1) begin
         tif.load     = 1'b1;
         tif.load_val = HOLD_LD;
      end else if (release_now && idx != LAST_IDX) begin
         tif.load = 1'b1;
      end
   end

   always_ff @(posedge auto_in_clock) begin
      if (auto_in_reset || sw_reset_req) begin
         state          <= ST_ASSERT;
         idx            <= '0;
         auto_out_reset <= '1;
         seq_done       <= 1'b0;
      end else begin
         case (state)
            ST_ASSERT: begin
               if (release_now) begin
                  auto_out_reset <= auto_out_reset & ~(NUM_OUT'(1) << idx);
                  idx            <= idx + IW'(1);
                  state          <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               // Run is entered one cycle after the final release.
               if (idx == DONE_IDX) begin
                  state    <= ST_RUN;
                  seq_done <= 1'b1;
               end else if (release_now) begin
                  auto_out_reset <= auto_out_reset & ~(NUM_OUT'(1) << idx);
                  idx            <= idx + IW'(1);
               end
            end
            ST_RUN:  seq_done <= 1'b1;
            default: state <= ST_ASSERT;
         endcase
      end
   end

`ifdef RESET_SEQ_COUNT_EN
   always_ff @(posedge auto_in_clock) begin
      if (auto_in_reset)
         seq_count <= '0;
      else if (sw_reset_req && seq_count != SEQ_COUNT_MAX)
         seq_count <= seq_count + SEQ_COUNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: two sequencer configurations share one stimulus stream and are
// checked against a cycle-index model of the release schedule.
module tb_reset_sequencer;
   localparam int N0 = 6, H0 = 16, S0 = 4;
   localparam int N1 = 1, H1 = 1,  S1 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, sw;
   logic [N0-1:0] oclk0, orst0;
   logic [N1-1:0] oclk1, orst1;
   logic          done0, done1;
`ifdef RESET_SEQ_COUNT_EN
   logic [7:0]    cnt0, cnt1;
`endif

   reset_sequencer #(.NUM_OUT(N0), .HOLD_CYCLES(H0), .STAGGER_CYCLES(S0)) dut0 (
      .auto_in_clock  (clk),
      .auto_in_reset  (rst),
      .sw_reset_req   (sw),
      .auto_out_clock (oclk0),
      .auto_out_reset (orst0),
      .seq_done       (done0)
`ifdef RESET_SEQ_COUNT_EN
      ,
      .seq_count      (cnt0)
`endif
   );

   reset_sequencer #(.NUM_OUT(N1), .HOLD_CYCLES(H1), .STAGGER_CYCLES(S1)) dut1 (
      .auto_in_clock  (clk),
      .auto_in_reset  (rst),
      .sw_reset_req   (sw),
      .auto_out_clock (oclk1),
      .auto_out_reset (orst1),
      .seq_done       (done1)
`ifdef RESET_SEQ_COUNT_EN
      ,
      .seq_count      (cnt1)
`endif
   );

   typedef struct {
      int            t;
      logic [N0-1:0] r0;
      logic          d0;
      logic [N1-1:0] r1;
      logic          d1;
      logic [7:0]    c;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   t      = 0;
   int   mcount = 0;

   // Domain i is held while the sequence is younger than hold + i*stagger cycles.
   function automatic logic [15:0] exp_rst(input int tt, input int n, input int h, input int s);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = (tt < h + i * s);
      return v;
   endfunction

   function automatic logic exp_done(input int tt, input int n, input int h, input int s);
      return tt >= h + (n - 1) * s + 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int tt);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d actual=%0h required=%0h", name, tt, act, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic s);
      exp_t        e;
      logic [15:0] v;
      rst = r;
      sw  = s;
      @(posedge clk);
      #1;
      if (r) begin
         t = 0; mcount = 0;
      end else if (s) begin
         t = 0;
         if (mcount < 255) mcount++;
      end else begin
         t++;
      end
      e.t  = t;
      v    = exp_rst(t, N0, H0, S0);
      e.r0 = v[N0-1:0];
      e.d0 = exp_done(t, N0, H0, S0);
      v    = exp_rst(t, N1, H1, S1);
      e.r1 = v[N1-1:0];
      e.d1 = exp_done(t, N1, H1, S1);
      e.c  = 8'(mcount);
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rst0",  32'(orst0), 32'(e.r0), e.t);
            chk("done0", 32'(done0), 32'(e.d0), e.t);
            chk("rst1",  32'(orst1), 32'(e.r1), e.t);
            chk("done1", 32'(done1), 32'(e.d1), e.t);
            chk("clk0",  32'(oclk0), 32'({N0{clk}}), e.t);
            chk("clk1",  32'(oclk1), 32'({N1{clk}}), e.t);
`ifdef RESET_SEQ_COUNT_EN
            chk("count0", 32'(cnt0), 32'(e.c), e.t);
            chk("count1", 32'(cnt1), 32'(e.c), e.t);
`endif
         end
      end
   end

   initial begin : stim
      rst = 1'b1;
      sw  = 1'b0;
      repeat (5) cycle(1'b1, 1'b0);
      // Full power-on sequence, then a software request in RUN at cycle 50.
      while (t < 50) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      // Request in the cycle whose edge would release bit 2.
      while (t < H0 + 2 * S0 - 1) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      // One-cycle hard reset mid-release.
      while (t < 25) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      while (t < 45) cycle(1'b0, 1'b0);
      // Hard reset and software request together: hard reset wins.
      cycle(1'b1, 1'b1);
      while (t < 45) cycle(1'b0, 1'b0);
      repeat (1500) begin
         cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 29) == 0));
      end
      while (t < 45) cycle(1'b0, 1'b0);
      // Back-to-back requests drive the counter into saturation.
      repeat (300) cycle(1'b0, 1'b1);
      repeat (45) cycle(1'b0, 1'b0);
      #20;
      chk("queue_drained", 32'(q.size()), 32'd0, t);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 6: number of sequenced reset domains, legal range 1..16.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles all resets stay asserted before the first release, legal value >=1.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 4: cycles between consecutive domain releases, legal value >=1.
REQ-004 SHALL have port auto_in_clock, input, width 1: the single clock.
REQ-005 SHALL have port auto_in_reset, input, width 1: reset, synchronous and active-high.
REQ-006 SHALL have port sw_reset_req, input, width 1: single-cycle request to re-run the reset sequence.
REQ-007 SHALL have port auto_out_clock, output, width NUM_OUT: each bit equals auto_in_clock, combinational pass-through.
REQ-008 SHALL have port auto_out_reset, output, width NUM_OUT: per-domain reset, active-high, registered.
REQ-009 SHALL have port seq_done, output, width 1: high when all domains are released.

Function
REQ-010 SHALL implement the FSM states ASSERT, RELEASE and RUN.
REQ-011 SHALL, in ASSERT, hold auto_out_reset at all-ones and count HOLD_CYCLES cycles, then move to RELEASE.
REQ-012 SHALL, in RELEASE, deassert auto_out_reset[i] in ascending order of i, one every STAGGER_CYCLES, and never reassert a released bit except through REQ-015 or REQ-016.
REQ-013 SHALL meet this release timing: cycle 0 is the first cycle in which auto_in_reset is sampled low, and auto_out_reset[i] first reads 0 in cycle HOLD_CYCLES + i*STAGGER_CYCLES.
REQ-014 SHALL enter RUN and raise seq_done one cycle after the last release, and hold seq_done high while in RUN.
REQ-015 SHALL, when sw_reset_req is sampled high in any state, make the next cycle have auto_out_reset at all-ones, seq_done at 0, state ASSERT and the timer cleared; that next cycle is cycle 0 of the new sequence.
REQ-016 SHALL treat sw_reset_req as having priority over a release or RUN entry scheduled in the same cycle.
REQ-017 SHALL, for NUM_OUT=1, release only bit 0 and not use STAGGER_CYCLES.
REQ-018 SHALL size the timer to cover max(HOLD_CYCLES, STAGGER_CYCLES), with no wrap-around reachable.

Reset
REQ-019 SHALL, on auto_in_reset high, drive state ASSERT, timer 0, domain index 0, auto_out_reset all-ones and seq_done 0.
REQ-020 SHALL let auto_in_reset override sw_reset_req.
REQ-021 SHALL, if auto_in_reset is asserted mid-sequence, restart the full sequence from REQ-013.

Configuration
REQ-022 SHALL, when macro RESET_SEQ_COUNT_EN is defined, add output seq_count, width 8: a count of sw_reset_req-triggered sequences that saturates at 255, resets to 0, and increments in the cycle sw_reset_req is accepted.
REQ-023 SHALL, when RESET_SEQ_COUNT_EN is not defined, have no seq_count port or logic and otherwise identical behaviour.

Structure
REQ-024 SHALL take the state enum type, the timer width function and parameter legality checks from package reset_seq_pkg.
REQ-025 SHALL instantiate one sub-module, reset_seq_timer: a loadable down-counter with a clear input and an expire flag.
REQ-026 SHALL keep the clock fan-out in the top level with no gating.

Verification
REQ-027 Power-on with defaults: auto_in_reset is high 5 cycles then low. Required: auto_out_reset[0] falls at cycle 16, [1] at 20, [2] at 24, [3] at 28, [4] at 32, [5] at 36, and seq_done rises at 37.
REQ-028 SW request in RUN: sw_reset_req pulses at cycle 50. Required: all resets are high at 51, bit 0 releases at 67, and seq_done rises at 88.
REQ-029 SW request mid-RELEASE: pulse in the cycle bit 2 is due to release. Required: bit 2 never falls in that cycle, all bits return high, and the sequence restarts.
REQ-030 Hard reset mid-sequence: auto_in_reset is high for 1 cycle at cycle 25. Required: all outputs are high, seq_done is 0, and timing restarts per REQ-013.
REQ-031 NUM_OUT=1, HOLD_CYCLES=1: release at cycle 1 and seq_done at cycle 2; with RESET_SEQ_COUNT_EN, 300 requests give seq_count 255.
